prf_multiport: RTL and testbench



---
 rtl/prf_multiport_pkg.sv | 23 ++
 rtl/prf_bypass_mux.sv | 43 ++++
 rtl/prf_multiport.sv | 105 ++++++++++
 tb/tb_prf_multiport.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/prf_multiport_pkg.sv
// ============================================================================
// Module      : prf_multiport_pkg
// Description : Shared register-file types and defaults for rename/issue/WB.
// Revision    : 1.0 - initial parametrised multiport release
// ============================================================================
`default_nettype none

package prf_multiport_pkg;

    localparam int PRF_NUM_PREGS = 64;
    localparam int PRF_DATA_W    = 32;
    localparam int PRF_NUM_RD    = 6;
    localparam int PRF_NUM_WR    = 3;
    localparam int PRF_NUM_ALLOC = 3;
    localparam int PRF_PREG_W    = $clog2(PRF_NUM_PREGS);

    // Packed ports carry one preg_t / word_t per port at slice [i*W +: W].
    typedef logic [PRF_PREG_W-1:0] preg_t;
    typedef logic [PRF_DATA_W-1:0] word_t;

endpackage

`default_nettype wire

// File: rtl/prf_bypass_mux.sv
// ============================================================================
// Module      : prf_bypass_mux
// Description : One read port: stored value overridden by same-cycle writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prf_bypass_mux #(
    parameter int NUM_WR = 3,
    parameter int PREG_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                     bypass_en_i,
    input  logic [PREG_W-1:0]        rd_addr_i,
    input  logic [DATA_W-1:0]        stored_data_i,
    input  logic                     stored_ready_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*PREG_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     rd_ready_o
);

    always_comb begin
        rd_data_o  = stored_data_i;
        rd_ready_o = stored_ready_i;
        if (rd_addr_i == '0) begin
            rd_data_o  = '0;
            rd_ready_o = 1'b1;
        end else if (bypass_en_i) begin
            // Ascending scan: the highest matching port index is applied last.
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*PREG_W +: PREG_W] == rd_addr_i)) begin
                    rd_data_o  = wr_data_i[j*DATA_W +: DATA_W];
                    rd_ready_o = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prf_multiport.sv
// ============================================================================
// Module      : prf_multiport
// Description : Physical register file with bypassed reads, ready bits and
//               write-conflict flag.
// Revision    : 1.0 - initial parametrised multiport release
// ============================================================================
`default_nettype none

module prf_multiport
    import prf_multiport_pkg::*;
#(
    parameter int NUM_PREGS = PRF_NUM_PREGS,
    parameter int DATA_W    = PRF_DATA_W,
    parameter int NUM_RD    = PRF_NUM_RD,
    parameter int NUM_WR    = PRF_NUM_WR,
    parameter int NUM_ALLOC = PRF_NUM_ALLOC
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_RD*$clog2(NUM_PREGS)-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]              rd_data,
    output logic [NUM_RD-1:0]                     rd_ready,
    input  logic [NUM_WR-1:0]                     wr_en,
    input  logic [NUM_WR*$clog2(NUM_PREGS)-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]              wr_data,
    input  logic [NUM_ALLOC-1:0]                  alloc_en,
    input  logic [NUM_ALLOC*$clog2(NUM_PREGS)-1:0] alloc_addr,
    output logic                                  wr_conflict
);

    localparam int PREG_W = $clog2(NUM_PREGS);

    logic [DATA_W-1:0]    mem_q [NUM_PREGS];
    logic [NUM_PREGS-1:0] ready_q;
    logic                 conflict_q;
    logic                 conflict_d;

    // Only effective (nonzero-address) writes can collide.
    always_comb begin
        conflict_d = 1'b0;
        for (int a = 0; a < NUM_WR; a++) begin
            for (int b = a + 1; b < NUM_WR; b++) begin
                if (wr_en[a] && wr_en[b]
                    && (wr_addr[a*PREG_W +: PREG_W] != '0)
                    && (wr_addr[a*PREG_W +: PREG_W] == wr_addr[b*PREG_W +: PREG_W])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                mem_q[i] <= '0;
            end
            ready_q    <= '1;
            conflict_q <= 1'b0;
        end else begin
            // Alloc clears go first so a same-cycle write leaves the bit set.
            for (int k = 0; k < NUM_ALLOC; k++) begin
                if (alloc_en[k] && (alloc_addr[k*PREG_W +: PREG_W] != '0)) begin
                    ready_q[alloc_addr[k*PREG_W +: PREG_W]] <= 1'b0;
                end
            end
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*PREG_W +: PREG_W] != '0)) begin
                    mem_q[wr_addr[j*PREG_W +: PREG_W]]   <= wr_data[j*DATA_W +: DATA_W];
                    ready_q[wr_addr[j*PREG_W +: PREG_W]] <= 1'b1;
                end
            end
            conflict_q <= conflict_d;
        end
    end

    assign wr_conflict = conflict_q;

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            prf_bypass_mux #(
                .NUM_WR (NUM_WR),
                .PREG_W (PREG_W),
                .DATA_W (DATA_W)
            ) u_bypass (
                .bypass_en_i    (!reset),
                .rd_addr_i      (rd_addr[i*PREG_W +: PREG_W]),
                .stored_data_i  (mem_q[rd_addr[i*PREG_W +: PREG_W]]),
                .stored_ready_i (ready_q[rd_addr[i*PREG_W +: PREG_W]]),
                .wr_en_i        (wr_en),
                .wr_addr_i      (wr_addr),
                .wr_data_i      (wr_data),
                .rd_data_o      (rd_data[i*DATA_W +: DATA_W]),
                .rd_ready_o     (rd_ready[i])
            );
        end
    endgenerate

    always @(posedge clk) begin
        assert (reset || (mem_q[0] == '0));
        assert (reset || ready_q[0]);
    end

endmodule

`default_nettype wire

// File: tb/tb_prf_multiport.sv
// ============================================================================
// Module      : tb_prf_multiport
// Description : Directed vector table plus reset corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prf_multiport;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [35:0]  rd_addr = '0;
    logic [191:0] rd_data;
    logic [5:0]   rd_ready;
    logic [2:0]   wr_en = '0;
    logic [17:0]  wr_addr = '0;
    logic [95:0]  wr_data = '0;
    logic [2:0]   alloc_en = '0;
    logic [17:0]  alloc_addr = '0;
    logic         wr_conflict;

    int n_cmp = 0;
    int n_bad = 0;

    prf_multiport dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .alloc_en    (alloc_en),
        .alloc_addr  (alloc_addr),
        .wr_conflict (wr_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  we;
        logic [17:0] wa;
        logic [95:0] wd;
        logic [2:0]  ae;
        logic [17:0] aa;
        logic [5:0]  ra;
        logic [31:0] ed;
        logic        er;
        logic        ec;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic [2:0] we, input logic [5:0] a0, a1, a2,
                                input logic [31:0] d0, d1, d2, input logic [2:0] ae,
                                input logic [5:0] l0, l1, input logic [5:0] ra,
                                input logic [31:0] ed, input logic er, ec);
        vec_t v;
        v.we = we; v.wa = {a2, a1, a0}; v.wd = {d2, d1, d0};
        v.ae = ae; v.aa = {6'd0, l1, l0}; v.ra = ra;
        v.ed = ed; v.er = er; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
        alloc_en = v.ae; alloc_addr = v.aa;
        rd_addr = {6{v.ra}};
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        logic [191:0] exp_bus;
        exp_bus = {6{v.ed}};
        chk({tag, "_data"}, rd_data, exp_bus);
        chk({tag, "_ready"}, {186'd0, rd_ready}, {186'd0, {6{v.er}}});
        chk({tag, "_conflict"}, {191'd0, wr_conflict}, {191'd0, v.ec});
    endtask

    vec_t idle;

    initial begin
        idle = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0);
        //           we      a0  a1  a2  d0            d1      d2    ae      l0  l1  ra  exp_data      rdy conf
        tbl[0]  = mk(3'b001,  5,  0,  0, 32'hDEADBEEF, 0,      0,    3'b000,  0,  0,  5, 32'hDEADBEEF, 1, 0);
        tbl[1]  = mk(3'b000,  0,  0,  0, 0,            0,      0,    3'b000,  0,  0,  5, 32'hDEADBEEF, 1, 0);
        tbl[2]  = mk(3'b101,  9,  0,  9, 32'h11,       0,      32'h22, 3'b000, 0,  0,  9, 32'h22,       1, 0);
        tbl[3]  = mk(3'b000,  0,  0,  0, 0,            0,      0,    3'b000,  0,  0,  9, 32'h22,       1, 1);
        tbl[4]  = mk(3'b000,  0,  0,  0, 0,            0,      0,    3'b000,  0,  0,  9, 32'h22,       1, 0);
        tbl[5]  = mk(3'b000,  0,  0,  0, 0,            0,      0,    3'b001, 12,  0, 12, 32'h0,        1, 0);
        tbl[6]  = mk(3'b000,  0,  0,  0, 0,            0,      0,    3'b000,  0,  0, 12, 32'h0,        0, 0);
        tbl[7]  = mk(3'b001, 12,  0,  0, 32'h5,        0,      0,    3'b000,  0,  0, 12, 32'h5,        1, 0);
        tbl[8]  = mk(3'b000,  0,  0,  0, 0,            0,      0,    3'b000,  0,  0, 12, 32'h5,        1, 0);
        tbl[9]  = mk(3'b110,  0,  0,  0, 0, 32'hFFFF, 32'hFFFF,      3'b001,  0,  0,  0, 32'h0,        1, 0);
        tbl[10] = mk(3'b000,  0,  0,  0, 0,            0,      0,    3'b000,  0,  0,  0, 32'h0,        1, 0);
        tbl[11] = mk(3'b001, 20,  0,  0, 32'h77,       0,      0,    3'b001, 20,  0, 20, 32'h77,       1, 0);
        tbl[12] = mk(3'b000,  0,  0,  0, 0,            0,      0,    3'b000,  0,  0, 20, 32'h77,       1, 0);
        tbl[13] = mk(3'b111, 30, 30, 30, 32'h1,        32'h2,  32'h3, 3'b000, 0,  0, 30, 32'h3,        1, 0);
        tbl[14] = mk(3'b000,  0,  0,  0, 0,            0,      0,    3'b000,  0,  0, 30, 32'h3,        1, 1);
        tbl[15] = mk(3'b011, 41, 40,  0, 32'h41,       32'hAB, 0,    3'b000,  0,  0, 41, 32'h41,       1, 0);
        tbl[16] = mk(3'b000,  0,  0,  0, 0,            0,      0,    3'b000,  0,  0, 40, 32'hAB,       1, 0);
        tbl[17] = mk(3'b010, 40, 40,  0, 32'hFF,       32'hCD, 0,    3'b000,  0,  0, 40, 32'hCD,       1, 0);
        tbl[18] = mk(3'b000,  0,  0,  0, 0,            0,      0,    3'b000,  0,  0, 40, 32'hCD,       1, 0);
        tbl[19] = mk(3'b000,  0,  0,  0, 0,            0,      0,    3'b011, 50, 50, 50, 32'h0,        1, 0);
        tbl[20] = mk(3'b000,  0,  0,  0, 0,            0,      0,    3'b000,  0,  0, 50, 32'h0,        0, 0);
        tbl[21] = mk(3'b001, 50,  0,  0, 32'h9,        0,      0,    3'b010,  0, 50, 50, 32'h9,        1, 0);
        tbl[22] = mk(3'b000,  0,  0,  0, 0,            0,      0,    3'b000,  0,  0, 50, 32'h9,        1, 0);

        // Reset, then sweep every address across all ports.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(idle);
        for (int a = 0; a < 64; a++) begin
            for (int p = 0; p < 6; p++) begin
                rd_addr[p*6 +: 6] = 6'((a + p) % 64);
            end
            #1;
            chk("reset_sweep_data", rd_data, 192'd0);
            chk("reset_sweep_ready", {186'd0, rd_ready}, {186'd0, 6'h3F});
        end
        chk("reset_conflict", {191'd0, wr_conflict}, 192'd0);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Distinct addresses on each port in one cycle.
        @(negedge clk);
        drive(idle);
        rd_addr = {6'd40, 6'd30, 6'd20, 6'd12, 6'd9, 6'd5};
        #1;
        chk("multi_addr_data", rd_data,
            {32'hCD, 32'h3, 32'h77, 32'h5, 32'h22, 32'hDEADBEEF});

        // Conflicting write of 7 plus alloc of 8, then reset during another write.
        @(negedge clk);
        drive(mk(3'b101, 7, 0, 7, 32'hA, 0, 32'hA, 3'b001, 8, 0, 7, 32'hA, 1, 0));
        #1;
        check_vec("pre_reset", mk(3'b101, 7, 0, 7, 32'hA, 0, 32'hA, 3'b001, 8, 0, 7, 32'hA, 1, 0));

        @(negedge clk);
        reset = 1'b1;
        drive(mk(3'b011, 7, 7, 0, 32'hB, 32'hC, 0, 3'b001, 8, 0, 7, 0, 1, 0));
        rd_addr[6 +: 6] = 6'd8;
        #1;
        chk("in_reset_data7", {160'd0, rd_data[31:0]}, {160'd0, 32'hA});
        chk("in_reset_ready8", {191'd0, rd_ready[1]}, 192'd0);
        chk("in_reset_conflict", {191'd0, wr_conflict}, {191'd0, 1'b1});

        @(negedge clk);
        reset = 1'b0;
        drive(idle);
        rd_addr = {6'd50, 6'd12, 6'd9, 6'd5, 6'd8, 6'd7};
        #1;
        chk("post_reset_data", rd_data, 192'd0);
        chk("post_reset_ready", {186'd0, rd_ready}, {186'd0, 6'h3F});
        chk("post_reset_conflict", {191'd0, wr_conflict}, 192'd0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
